// File: rtl/cpu_ctrl_sequencer.sv
// Instruction-cycle sequencer for the 8-bit CPU: fetch/decode/execute/memory/writeback
// with a memory-ready handshake, wait timeout and retired-instruction counter.
module cpu_ctrl_sequencer #(
  parameter int unsigned MEM_TIMEOUT = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [3:0] ir_opcode,
  input  logic       zero_flag,
  input  logic       mem_rdy,
  output logic       pc_inc,
  output logic       pc_load,
  output logic       addr_sel,
  output logic       mar_load,
  output logic       mem_rd,
  output logic       mem_wr,
  output logic       ir_load,
  output logic       a_load,
  output logic [1:0] a_sel,
  output logic       b_load,
  output logic       alu_sub,
  output logic       flags_load,
  output logic       out_load,
  output logic [2:0] state_o,
  output logic       halted,
  output logic       retire,
  output logic       illegal_op,
  output logic       bus_err,
  output logic [7:0] instr_count
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_F1   = 3'd1,
    S_F2   = 3'd2,
    S_DEC  = 3'd3,
    S_EX   = 3'd4,
    S_MEM  = 3'd5,
    S_WB   = 3'd6,
    S_HALT = 3'd7
  } state_t;

  localparam logic [3:0] OP_LDA = 4'h1;
  localparam logic [3:0] OP_ADD = 4'h2;
  localparam logic [3:0] OP_SUB = 4'h3;
  localparam logic [3:0] OP_STA = 4'h4;
  localparam logic [3:0] OP_LDI = 4'h5;
  localparam logic [3:0] OP_JMP = 4'h6;
  localparam logic [3:0] OP_JZ  = 4'h7;
  localparam logic [3:0] OP_OUT = 4'h8;
  localparam logic [3:0] OP_HLT = 4'hF;

  // Terminal count: the wait that would be the MEM_TIMEOUT-th unanswered cycle.
  localparam logic [7:0] WAIT_TC = 8'(MEM_TIMEOUT - 1);

  state_t     r_state;
  state_t     w_state_nxt;
  logic [3:0] r_opcode;
  logic [7:0] r_wait_cnt;
  logic       r_retire;
  logic       r_bus_err;
  logic [7:0] r_instr_count;
  logic       w_mem_wait;
  logic       w_timeout;
  logic       w_retire_evt;
  logic       w_mem_op;
  logic       w_addsub;

  assign w_mem_op   = (r_opcode == OP_LDA) || (r_opcode == OP_ADD) ||
                      (r_opcode == OP_SUB) || (r_opcode == OP_STA);
  assign w_addsub   = (r_opcode == OP_ADD) || (r_opcode == OP_SUB);
  assign w_mem_wait = ((r_state == S_F2) || (r_state == S_MEM)) && !mem_rdy;
  assign w_timeout  = w_mem_wait && (r_wait_cnt == WAIT_TC);

  always_comb begin
    w_state_nxt  = r_state;
    w_retire_evt = 1'b0;
    case (r_state)
      S_IDLE: if (start) w_state_nxt = S_F1;
      S_F1:   w_state_nxt = S_F2;
      S_F2: begin
        if (mem_rdy)        w_state_nxt = S_DEC;
        else if (w_timeout) w_state_nxt = S_HALT;
      end
      S_DEC:  w_state_nxt = S_EX;
      S_EX: begin
        if (w_mem_op) begin
          w_state_nxt = S_MEM;
        end else begin
          w_state_nxt  = (r_opcode == OP_HLT) ? S_HALT : S_F1;
          w_retire_evt = 1'b1;
        end
      end
      S_MEM: begin
        if (mem_rdy) begin
          if (w_addsub) begin
            w_state_nxt = S_WB;
          end else begin
            w_state_nxt  = S_F1;
            w_retire_evt = 1'b1;
          end
        end else if (w_timeout) begin
          w_state_nxt = S_HALT;
        end
      end
      S_WB: begin
        w_state_nxt  = S_F1;
        w_retire_evt = 1'b1;
      end
      S_HALT: if (start) w_state_nxt = S_F1;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_opcode      <= 4'h0;
      r_wait_cnt    <= 8'd0;
      r_retire      <= 1'b0;
      r_bus_err     <= 1'b0;
      r_instr_count <= 8'd0;
    end else begin
      r_state   <= w_state_nxt;
      r_retire  <= w_retire_evt;
      r_bus_err <= w_timeout;
      if (r_state == S_DEC) r_opcode <= ir_opcode;
      if (w_state_nxt != r_state) r_wait_cnt <= 8'd0;
      else if (w_mem_wait)        r_wait_cnt <= r_wait_cnt + 8'd1;
      if (w_retire_evt) r_instr_count <= r_instr_count + 8'd1;
    end
  end

  // Datapath strobes: a pure decode of the current state, opcode, mem_rdy and Z.
  always_comb begin
    pc_inc     = 1'b0;
    pc_load    = 1'b0;
    addr_sel   = 1'b0;
    mar_load   = 1'b0;
    mem_rd     = 1'b0;
    mem_wr     = 1'b0;
    ir_load    = 1'b0;
    a_load     = 1'b0;
    a_sel      = 2'd0;
    b_load     = 1'b0;
    alu_sub    = 1'b0;
    flags_load = 1'b0;
    out_load   = 1'b0;
    illegal_op = 1'b0;
    case (r_state)
      S_F1: mar_load = 1'b1;
      S_F2: begin
        mem_rd  = 1'b1;
        ir_load = mem_rdy;
        pc_inc  = mem_rdy;
      end
      S_EX: begin
        case (r_opcode)
          4'h0: ;
          OP_LDA, OP_ADD, OP_SUB, OP_STA: begin
            addr_sel = 1'b1;
            mar_load = 1'b1;
          end
          OP_LDI: begin
            a_load = 1'b1;
            a_sel  = 2'd2;
          end
          OP_JMP: pc_load  = 1'b1;
          OP_JZ:  pc_load  = zero_flag;
          OP_OUT: out_load = 1'b1;
          OP_HLT: ;
          default: illegal_op = 1'b1;
        endcase
      end
      S_MEM: begin
        mem_wr = (r_opcode == OP_STA);
        mem_rd = !(r_opcode == OP_STA);
        a_load = mem_rdy && (r_opcode == OP_LDA);
        b_load = mem_rdy && w_addsub;
      end
      S_WB: begin
        a_load     = 1'b1;
        a_sel      = 2'd1;
        alu_sub    = (r_opcode == OP_SUB);
        flags_load = 1'b1;
      end
      default: ;
    endcase
  end

  assign state_o     = r_state;
  assign halted      = (r_state == S_HALT);
  assign retire      = r_retire;
  assign bus_err     = r_bus_err;
  assign instr_count = r_instr_count;

endmodule

// File: doc/cpu_ctrl_sequencer.md
Name: cpu_ctrl_sequencer

Overview:
Instruction-cycle control unit for the 8-bit CPU. It runs a Moore FSM through fetch, decode, execute, memory and writeback. It emits the per-cycle control word for the PC, MAR, IR, A/B registers, ALU and memory, and waits on a memory-ready handshake with a timeout. It sits between the instruction register/flags and the datapath, and is the only source of datapath load/enable strobes.

Parameters:
MEM_TIMEOUT, 8, max cycles to wait for mem_rdy in F2/MEM before bus error (1..255)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous active-high reset
start  in  1  leave IDLE or HALT and begin fetch
ir_opcode  in  4  IR[7:4], valid in DEC
zero_flag  in  1  registered Z flag from ALU flags reg
mem_rdy  in  1  memory read data valid / write accepted this cycle
pc_inc  out  1  increment PC
pc_load  out  1  load PC from IR operand
addr_sel  out  1  MAR source: 0=PC, 1=IR operand
mar_load  out  1  load MAR
mem_rd  out  1  memory read request
mem_wr  out  1  memory write request (data = A)
ir_load  out  1  load IR from memory data
a_load  out  1  load A
a_sel  out  2  A source: 0=MEM, 1=ALU, 2=IMM (IR[3:0] zero-extended)
b_load  out  1  load B from memory data
alu_sub  out  1  ALU subtract (else add)
flags_load  out  1  load Z/C flags
out_load  out  1  load output register from A
state_o  out  3  current state encoding
halted  out  1  high in HALT
retire  out  1  one-cycle pulse on instruction completion
illegal_op  out  1  one-cycle pulse in EX for undefined opcode
bus_err  out  1  one-cycle pulse on memory timeout
instr_count  out  8  retired-instruction counter, wraps 255->0

Behaviour:
- Opcodes: 0 NOP, 1 LDA, 2 ADD, 3 SUB, 4 STA, 5 LDI, 6 JMP, 7 JZ, 8 OUT, F HLT. 9–E are illegal and execute as NOP with illegal_op.
- States: IDLE=0, F1=1, F2=2, DEC=3, EX=4, MEM=5, WB=6, HALT=7.
- Registers: state_q, opcode_q, wait counter, instr_count, and registered pulse flags.
- Control outputs are decoded only from state_q, opcode_q, mem_rdy and zero_flag. Every output not listed for a state is 0.
- Reset (async, any time): state IDLE, opcode_q=0, counter=0, instr_count=0, all outputs 0 (state_o=0, halted=0). This holds mid-instruction too; there is no partial completion.
- IDLE: start -> F1; otherwise stay.
- F1: addr_sel=0, mar_load=1 -> F2.
- F2: mem_rd=1.
  - If mem_rdy: ir_load=1, pc_inc=1 -> DEC.
  - Else the wait counter increments. At MEM_TIMEOUT waiting cycles: bus_err pulses -> HALT.
- DEC: opcode_q <= ir_opcode -> EX.
- EX, by opcode_q:
  - NOP/illegal -> F1 (retire).
  - LDA/ADD/SUB/STA: addr_sel=1, mar_load=1 -> MEM.
  - LDI: a_load=1, a_sel=2 -> F1.
  - JMP: pc_load=1 -> F1.
  - JZ: pc_load=zero_flag -> F1.
  - OUT: out_load=1 -> F1.
  - HLT -> HALT (retire).
- MEM: LDA/ADD/SUB assert mem_rd=1; STA asserts mem_wr=1. On mem_rdy:
  - LDA: a_load=1, a_sel=0 -> F1.
  - ADD/SUB: b_load=1 -> WB.
  - STA -> F1.
  - Same timeout rule as F2.
- WB: a_load=1, a_sel=1, alu_sub=(opcode_q==3), flags_load=1 -> F1.
- Wait counter clears on every state change. Requests stay asserted continuously while waiting.
- retire pulses on the cycle after every completing transition (into F1 from EX/MEM/WB, or EX->HALT on HLT). instr_count increments by 1 on the same edge that sets retire. A bus_err abort does not retire.
- HALT: halted=1, no strobes. start -> F1, resuming at the current PC.
- start is ignored outside IDLE/HALT.
- Latency with mem_rdy asserted immediately:
  - NOP/LDI/JMP/JZ/OUT/HLT: 4 cycles (F1..EX).
  - LDA/STA: 5 cycles.
  - ADD/SUB: 6 cycles.
  - Each extra wait cycle adds 1.

Test Plan:
- Reset then start pulse, mem_rdy=1, opcode 5 → states 1,2,3,4,1. a_load=1 with a_sel=2 in EX. retire one cycle later. instr_count=1.
- ADD (opcode 2) with mem_rdy held low 3 cycles in MEM → MEM lasts 4 cycles with mem_rd high throughout. b_load on the 4th cycle. WB asserts a_load, a_sel=1, alu_sub=0, flags_load. Total 9 cycles.
- JZ with zero_flag=0 then =1 → pc_load 0 then 1 in EX. STA → mem_wr only in MEM, never mem_rd.
- mem_rdy stuck low in F2 with MEM_TIMEOUT=8 → bus_err pulses once after 8 wait cycles, then HALT, halted=1, instr_count unchanged. A later start → F1.
- Opcode B → illegal_op pulse in EX, no datapath strobes, retire. HLT → HALT; start ignored during F1–WB; 256 retires wrap instr_count to 0.
- Assert rst in MEM of an LDA → same-cycle async return to IDLE, all outputs 0, instr_count=0. Start still needed to refetch.
